// File: rtl/acc8_stream_pkg.sv
// Shared definitions for the acc8_stream packet accumulator.
// Holds the controller state encoding and the default counter width.
package acc8_stream_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc8_stream_bit8_adder.sv
// Existing 8-bit ripple-carry adder: y = a + b, c = carry-out.
// Kept as a plain chain of full adders so timing matches the legacy block.
module bit8_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       c
);

  logic [8:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign y[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c = carry[8];

endmodule

// File: rtl/acc8_stream.sv
// Stream accumulator: sums a packet of 8-bit operands through bit8_adder,
// counts carry-outs, and holds the total on out_* until the consumer takes it.
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | no operand of the current packet accepted
//   ACC     | at least one operand accepted, no last yet
//   HOLD    | result presented, waiting for out_ready
module acc8_stream
  import acc8_stream_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic [CNT_W-1:0] out_carry_cnt,
  output logic [CNT_W-1:0] out_nops,
  output logic             out_ovf
);

  acc_state_e       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] nops_q, nops_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;

  logic [7:0]       add_y;
  logic             add_c;
  logic             accept;

  bit8_adder u_adder (
    .a (acc_q),
    .b (in_data),
    .y (add_y),
    .c (add_c)
  );

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    nops_d      = nops_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (accept) begin
          acc_d = add_y;
          if (add_c) begin
            // Once the carry counter is full, further carries only flag overflow.
            if (carry_cnt_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              carry_cnt_d = carry_cnt_q + CNT_W'(1);
            end
          end
          if (nops_q != '1) begin
            nops_d = nops_q + CNT_W'(1);
          end
          state_d = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          acc_d       = 8'h00;
          carry_cnt_d = '0;
          nops_d      = '0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered so in_ready never has a combinational path from out_ready.
    in_ready_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= 8'h00;
      carry_cnt_q <= '0;
      nops_q      <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      nops_q      <= nops_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q == ST_HOLD);
  assign out_sum       = acc_q;
  assign out_carry_cnt = carry_cnt_q;
  assign out_nops      = nops_q;
  assign out_ovf       = ovf_q;

endmodule

// File: doc/acc8_stream.md
Name: acc8_stream

Overview:
- Sequential operand accumulator that sits directly in front of the existing 8-bit ripple adder (bit8_adder) and consumes its sum and carry outputs.
- Accepts a packet of 8-bit operands over a valid/ready stream and sums them one per cycle through one bit8_adder instance.
- Tracks carry-outs, then presents the packet total on a held output handshake to the downstream consumer.

Parameters:
- CNT_W, 4, width of the carry counter and the operand counter; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  block can accept operand this cycle
- in_data  input  8  operand
- in_last  input  1  qualifies in_data as final operand of packet
- out_valid  output  1  result held and valid
- out_ready  input  1  downstream accepts result
- out_sum  output  8  low 8 bits of packet total
- out_carry_cnt  output  CNT_W  number of carry-outs generated during packet (saturating)
- out_nops  output  CNT_W  operands accepted in packet (saturating)
- out_ovf  output  1  sticky: carry counter saturated and another carry occurred

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst dominates all other inputs in the cycle it is sampled.
- Reset values: state=IDLE; acc=0x00; carry_cnt=0; nops=0; ovf=0; out_valid=0; in_ready=0 while rst is high, then 1 in the first cycle after release.
- States:
  - IDLE: no operand accepted yet.
  - ACC: at least one operand accepted.
  - HOLD: result presented.
- in_ready: 1 in IDLE and ACC, 0 in HOLD. The ready signal is registered state only; it has no combinational path from out_ready.
- Accept: when in_valid & in_ready:
  - bit8_adder a=acc, b=in_data.
  - acc <= y.
  - If c=1: carry_cnt <= carry_cnt+1, saturating. If carry_cnt is already all-ones, ovf <= 1 instead.
  - nops <= nops+1, saturating.
- Transitions:
  - IDLE -> ACC on accept with in_last=0.
  - IDLE or ACC -> HOLD on accept with in_last=1.
  - HOLD -> IDLE on out_valid & out_ready. In the same edge, acc, carry_cnt, nops and ovf are cleared.
- Latency: last operand accepted at edge t; out_valid=1 and outputs valid from t+1.
- HOLD output stability:
  - out_sum, out_carry_cnt, out_nops and out_ovf stay stable while out_valid=1 and out_ready=0.
  - in_valid is ignored in HOLD; the source holds its data.
- Throughput: no same-cycle bypass. After the result handshake at edge t, in_ready=1 from t+1. Minimum packet period is N+1 cycles for N operands.
- Exact total: {out_carry_cnt, out_sum} equals the packet total when out_ovf=0.
- in_valid=0 cycles (bubbles): state and accumulators unchanged.
- out_ready asserted outside HOLD: no effect.
- Reset mid-packet: partial sum discarded. No result is emitted for that packet.
- A packet is defined only by in_last; there is no maximum length. nops saturates silently and does not drive ovf.
- Outputs in IDLE/ACC: out_* fields show internal registers but are qualified only by out_valid. The bench must not check them while out_valid=0.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ACC=2'd1, HOLD=2'd2) and the default CNT_W constant.
- Sub-module: one instance of the existing bit8_adder. No other sub-modules; the FSM and counters are inline.

Test Plan:
- Single operand 0x25 with in_last=1 -> next cycle out_valid=1, out_sum=0x25, out_carry_cnt=0, out_nops=1, out_ovf=0.
- Operands 0xFF, 0x01, then 0x02 with last -> out_sum=0x02, out_carry_cnt=1, out_nops=3.
- CNT_W=2, five operands of 0xFF (last on 5th) -> total 0x4FB: out_sum=0xFB, out_carry_cnt=3 (saturated), out_ovf=1, out_nops=3 (saturated).
- Backpressure: result 0x30 held with out_ready=0 for 5 cycles while in_valid=1, in_data=0x77 -> outputs constant, in_ready=0, no accept. Then out_ready=1 for one cycle -> next packet 0x11 with last gives out_sum=0x11.
- Reset mid-packet: accept 0x10 and 0x20, assert rst 1 cycle, then send 0x05 with last -> out_sum=0x05, out_nops=1, carry 0.
- Bubbles: 0x40, two idle cycles, 0x40, idle, 0x81 with last -> out_sum=0x01, out_carry_cnt=1, out_nops=3.
